// File: rtl/tx_engine_pkg.sv
// Shared frame constants, state/parity encodings and frame builder
// for the serial transmit engine.
package tx_engine_pkg;

  localparam int FRAME_LEN = 11;
  localparam int CNT_W     = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_e;

  // Bit 0 is the start bit; unused tail positions stay at the stop level.
  function automatic logic [FRAME_LEN-1:0] build_frame(
    input logic [7:0] d,
    input logic       eight,
    input logic       pen,
    input par_e       sense
  );
    logic [7:0]           dat;
    logic                 par;
    logic [FRAME_LEN-1:0] f;
    dat    = eight ? d : {1'b0, d[6:0]};
    par    = (^dat) ^ (sense == PAR_ODD);
    f      = '1;
    f[0]   = 1'b0;
    f[7:1] = d[6:0];
    if (eight) begin
      f[8] = d[7];
      if (pen) f[9] = par;
    end else if (pen) begin
      f[8] = par;
    end
    return f;
  endfunction

endpackage

// File: rtl/tx_engine_bit_timer.sv
// Bit-period timer: one-cycle done pulse every baud_k+1 cycles
// while enabled; count held at zero when disabled.
module bit_timer #(
  parameter int KW = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [KW-1:0] baud_k,
  output logic          done
);

  logic [KW-1:0] cnt_q, cnt_d;

  assign done = en && (cnt_q == baud_k);

  always_comb begin
    cnt_d = '0;
    if (en && !done) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tx_engine.sv
// Serial transmit engine: start bit, 7/8 data bits, optional parity,
// stop-level fill to a fixed 11-bit frame.
module tx_engine
  import tx_engine_pkg::*;
#(
  parameter int KW = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [7:0]    D,
  input  logic [KW-1:0] baud_k,
  input  logic          eight,
  input  logic          pen,
  input  logic          ohel,
  output logic          tx,
  output logic          txrdy
);

  state_e               state_q, state_d;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [KW-1:0]        baud_q, baud_d;
  logic                 tx_q, tx_d;
  logic                 txrdy_q, txrdy_d;
  logic                 bit_done;
  logic [FRAME_LEN-1:0] frame;

  assign frame = build_frame(D, eight, pen, par_e'(ohel));

  bit_timer #(.KW(KW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == ST_SHIFT),
    .baud_k (baud_q),
    .done   (bit_done)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    baud_d   = baud_q;
    tx_d     = tx_q;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (load) begin
          state_d  = ST_SHIFT;
          shreg_d  = {1'b1, frame[FRAME_LEN-1:1]};
          bitcnt_d = '0;
          baud_d   = baud_k;
          tx_d     = frame[0];
        end
      end
      ST_SHIFT: begin
        if (bit_done) begin
          if (bitcnt_q == CNT_W'(FRAME_LEN - 1)) begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end else begin
            tx_d     = shreg_q[0];
            shreg_d  = {1'b1, shreg_q[FRAME_LEN-1:1]};
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    txrdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      baud_q   <= '0;
      tx_q     <= 1'b1;
      txrdy_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      baud_q   <= baud_d;
      tx_q     <= tx_d;
      txrdy_q  <= txrdy_d;
    end
  end

  assign tx    = tx_q;
  assign txrdy = txrdy_q;

endmodule

// File: doc/tx_engine.md
TX_ENGINE -- requirements
Module: tx_engine

Interface
REQ-001 Parameter: KW, 19, width of the baud bit-time input.
REQ-002 Port: clk  in  1  rising-edge clock for all state.
REQ-003 Port: rst  in  1  reset; synchronous, active-high.
REQ-004 Port: load  in  1  one-cycle strobe requesting transmission of D.
REQ-005 Port: D  in  8  parallel byte to send, sampled on an accepted load.
REQ-006 Port: baud_k  in  KW  bit time in clk cycles minus one, sampled on an accepted load.
REQ-007 Port: eight  in  1  1 = 8 data bits, 0 = 7 data bits (D[7] ignored), sampled on an accepted load.
REQ-008 Port: pen  in  1  parity enable, sampled on an accepted load.
REQ-009 Port: ohel  in  1  parity sense: 0 = even, 1 = odd, sampled on an accepted load.
REQ-010 Port: tx  out  1  serial line, registered, idle high.
REQ-011 Port: txrdy  out  1  registered, high when a load will be accepted.

Function
REQ-012 The block SHALL implement a two-state machine: IDLE (txrdy=1, tx=1) and SHIFT (txrdy=0).
REQ-013 A load SHALL be accepted only in a cycle where txrdy=1; a load with txrdy=0 SHALL be ignored with no effect on the frame in progress.
REQ-014 On acceptance, the block SHALL enter SHIFT, and tx SHALL be 0 (start bit) and txrdy SHALL be 0 from the next cycle.
REQ-015 Frame length SHALL always be 11 bit periods in this order: start 0, D[0]..D[6], D[7] if eight, parity if pen, then 1s filling to 11 bits.
REQ-016 Parity SHALL be the XOR of the transmitted data bits (7 or 8), inverted when ohel=1.
REQ-017 Each bit period SHALL last exactly baud_k+1 clk cycles; baud_k=0 gives 1-cycle bits.
REQ-018 Values of D, baud_k, eight, pen and ohel SHALL be captured at acceptance; changes during SHIFT SHALL not affect the frame.
REQ-019 The machine SHALL return to IDLE with txrdy=1 in the cycle after the 11th bit period ends, so that txrdy is low for exactly 11*(baud_k+1) cycles.
REQ-020 A load in the first cycle txrdy returns to 1 SHALL be accepted, giving back-to-back frames with no idle gap beyond that one cycle.
REQ-021 The bit-period counter SHALL be KW bits wide and SHALL not wrap mid-period for any baud_k up to 2^KW-1.

Reset
REQ-022 rst=1 at a rising edge SHALL force IDLE, tx=1, txrdy=1, and clear the shift register and counters, including mid-frame.
REQ-023 A load asserted in the same cycle as rst SHALL be ignored.
REQ-024 After rst deasserts, the block SHALL accept a load on the first clock edge.

Structure
REQ-025 The frame length (11), the state encodings and the parity-sense encoding SHALL be defined in a shared package.
REQ-026 The bit timer SHALL be a sub-module, bit_timer, that generates a one-cycle done pulse every baud_k+1 cycles while enabled and resets its count when disabled.
REQ-027 The remaining logic SHALL be an 11-bit right-shift register, a 4-bit bit counter and the state register.

Verification
REQ-028 baud_k=3, eight=1, pen=0, load D=0x55 -> tx = 0,1,0,1,0,1,0,1,0,1,1, each held 4 cycles; txrdy low for 44 cycles.
REQ-029 baud_k=0, eight=1, pen=1, D=0x41 with ohel=0 -> parity bit (bit 9) = 0; repeat with ohel=1 -> parity bit = 1.
REQ-030 baud_k=1, eight=0, pen=1, ohel=0, D=0xC1 -> data bits 1,0,0,0,0,0,1; parity 0; bits 9-10 = 1,1; D[7] never appears on tx.
REQ-031 Load 0xAA, then load 0x00 at cycle 5 while busy -> only the 0xAA frame is sent; txrdy and tx are unaffected by the second load.
REQ-032 baud_k=2, load 0xFF, assert rst during bit 4 -> next cycle tx=1, txrdy=1; a load of 0x0F two cycles later produces a complete, correct frame.
REQ-033 baud_k=0, load 0x12 and load 0x34 in the first cycle txrdy returns -> the two frames are separated by exactly one idle-high cycle.
